// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake and carry/overflow/zero flags.
// Optional clamp-on-overflow output enabled by defining SATURATE_EN.
module pipelined_add_sub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int SW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  logic advance;

  // Operands, partial result, carry and valid presented to each stage
  logic [WIDTH-1:0] ops_a  [STAGES];
  logic [WIDTH-1:0] ops_bx [STAGES];
  logic [WIDTH-1:0] ops_s  [STAGES];
  logic             ops_c  [STAGES];
  logic             ops_v  [STAGES];

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  assign ops_a[0]  = A;
  assign ops_bx[0] = sub ? ~B : B;
  assign ops_s[0]  = '0;
  assign ops_c[0]  = Cin;
  assign ops_v[0]  = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      slice_sum;
    logic [WIDTH-1:0] s_nxt;
    logic             unused_slice;

    assign slice_sum = {1'b0, ops_a[k][k*SW +: SW]} + {1'b0, ops_bx[k][k*SW +: SW]}
                     + {{SW{1'b0}}, ops_c[k]};

    always_comb begin
      s_nxt               = ops_s[k];
      s_nxt[k*SW +: SW]   = slice_sum[SW-1:0];
    end

    assign unused_slice = ^ops_s[k][k*SW +: SW];

    if (k > 0) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^{ops_a[k][k*SW-1:0], ops_bx[k][k*SW-1:0]};
    end

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] bx_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             v_q;

      // Every stage shifts together on advance; a stall freezes the whole pipe
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bx_q <= '0;
          s_q  <= '0;
          c_q  <= 1'b0;
          v_q  <= 1'b0;
        end else if (advance) begin
          a_q  <= ops_a[k];
          bx_q <= ops_bx[k];
          s_q  <= s_nxt;
          c_q  <= slice_sum[SW];
          v_q  <= ops_v[k];
        end
      end

      assign ops_a[k+1]  = a_q;
      assign ops_bx[k+1] = bx_q;
      assign ops_s[k+1]  = s_nxt_hold(s_q);
      assign ops_c[k+1]  = c_q;
      assign ops_v[k+1]  = v_q;
    end else begin : g_last
      logic             ovf;
      logic [WIDTH-1:0] s_fin;

      assign ovf = (ops_a[k][MSB] == ops_bx[k][MSB]) & (s_nxt[MSB] != ops_a[k][MSB]);

`ifdef SATURATE_EN
      always_comb begin
        s_fin = s_nxt;
        if (ovf) begin
          s_fin = ops_a[k][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
      end
`else
      assign s_fin = s_nxt;
`endif

      // Final stage doubles as the output register, so flags are computed before capture
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          S         <= '0;
          Cout      <= 1'b0;
          V         <= 1'b0;
          Z         <= 1'b0;
        end else if (advance) begin
          out_valid <= ops_v[k];
          S         <= s_fin;
          Cout      <= slice_sum[SW];
          V         <= ovf;
          Z         <= (s_fin == '0);
        end
      end
    end
  end

  function automatic logic [WIDTH-1:0] s_nxt_hold(input logic [WIDTH-1:0] s);
    return s;
  endfunction

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub (WIDTH=32, STAGES=2); follows SATURATE_EN if defined.
module tb_pipelined_add_sub;

  localparam int     WIDTH  = 32;
  localparam int     STAGES = 2;
  localparam longint MAXPOS = 64'sd2147483647;
  localparam longint MAXNEG = -64'sd2147483648;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        v;
    logic        z;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] S;
  logic        Cout;
  logic        V;
  logic        Z;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   pat_en = 0;
  int   pat_idx = 0;
  exp_t sb[$];

  bit          stall_prev = 0;
  logic [35:0] held;

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .V(V), .Z(Z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready pattern 1,0,1,1,0 repeating while enabled
  always @(posedge clk) begin
    #1;
    if (pat_en) begin
      out_ready = !((pat_idx % 5) == 1 || (pat_idx % 5) == 4);
      pat_idx++;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Reference: plain 33-bit unsigned sum for S/Cout, true signed sum for overflow
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic op_sub, input int acc, input bit lat);
    exp_t        e;
    logic [31:0] bx;
    logic [32:0] u;
    longint      sres;
    bx     = op_sub ? ~b : b;
    u      = {1'b0, a} + {1'b0, bx} + {32'b0, cin};
    sres   = longint'($signed(a)) + longint'($signed(bx)) + longint'(cin);
    e.v    = (sres > MAXPOS) || (sres < MAXNEG);
    e.cout = u[32];
    e.s    = u[31:0];
`ifdef SATURATE_EN
    if (e.v) e.s = (sres > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.z    = (e.s == 32'h0);
    e.acc  = acc;
    e.lat  = lat;
    return e;
  endfunction

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic op_sub, input bit lat);
    bit done;
    done     = 0;
    A        = a;
    B        = b;
    Cin      = cin;
    sub      = op_sub;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, cin, op_sub, cyc + 1, lat));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_output("accepted", {63'b0, done}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_output("drain_left", sb.size(), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever a result beat transfers
  always @(negedge clk) begin
    logic exp_rdy;
    exp_t e;
    if (rst_n) begin
      exp_rdy = !out_valid || out_ready;
      check_output("in_ready", {63'b0, in_ready}, {63'b0, exp_rdy});
      if (stall_prev) check_output("stall_stable", {out_valid, S, Cout, V, Z}, held);
      stall_prev = out_valid && !out_ready;
      held       = {out_valid, S, Cout, V, Z};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_beat", {31'b0, S, Cout, V, Z}, 64'h0);
        end else begin
          e = sb.pop_front();
          check_output("result", {S, Cout, V, Z}, {e.s, e.cout, e.v, e.z});
          if (e.lat) check_output("latency", cyc, e.acc + STAGES - 1);
        end
      end
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    check_output("reset_outputs", {out_valid, S, Cout, V, Z}, 64'd0);
    check_output("reset_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] directed beats");
    apply_stimulus(32'd2, 32'd5, 1'b1, 1'b0, 1);
    wait_drain();
    apply_stimulus(32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 1);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    apply_stimulus(32'd15, 32'd45, 1'b1, 1'b1, 1);
    apply_stimulus(32'd46331, 32'd46331, 1'b1, 1'b1, 1);
    apply_stimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1);
    apply_stimulus(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1);
    apply_stimulus(32'h1234_5678, 32'd0, 1'b1, 1'b1, 1);
    apply_stimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    wait_drain();

    $display("[TB] random back-to-back with backpressure");
    pat_en = 1;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end
    pat_en    = 0;
    out_ready = 1'b1;
    wait_drain();

    $display("[TB] random with bubbles");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();

    $display("[TB] reset with beats in flight");
    apply_stimulus(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1);
    apply_stimulus(32'hAAAA_5555, 32'h1111_2222, 1'b0, 1'b0, 1);
    rst_n = 1'b0;
    #1;
    check_output("midreset_outputs", {out_valid, S, Cout, V, Z}, 64'd0);
    check_output("midreset_in_ready", {63'b0, in_ready}, 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_stimulus(32'd100, 32'd23, 1'b0, 1'b0, 1);
    wait_drain();
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
